// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, 3-sample majority vote,
// one-cycle rx_done per good byte and frame_error per bad stop bit.
module uart_rx #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_error,
    output logic       busy
);

    localparam int H  = CLK_DIV >> 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            s1;
    logic [2:0]      h;
    logic            rx_s;
    logic            smp;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [2:0]      idx;
    logic [2:0]      idx_nx;
    logic [7:0]      sh;
    logic [7:0]      sh_nx;
    logic [7:0]      data_nx;
    logic            done_nx;
    logic            ferr_nx;

    // h[0] is the second synchroniser flop; h[2:1] are its recent past
    assign rx_s = h[0];
    assign smp  = (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b1;
            h           <= 3'b111;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            sh          <= '0;
            rx_data     <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            s1          <= rx;
            h           <= {h[1:0], s1};
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            sh          <= sh_nx;
            rx_data     <= data_nx;
            rx_done     <= done_nx;
            frame_error <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sh_nx    = sh;
        data_nx  = rx_data;
        done_nx  = 1'b0;
        ferr_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cnt_nx   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx = '0;
                    if (smp) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                        idx_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    sh_nx  = {smp, sh[7:1]};
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (smp) begin
                        data_nx  = sh;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = BRK;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            // a held-low line stays here so it reports only once
            BRK: begin
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx; expected bytes come from
// a frame-level model of what each transmitted frame should yield.
module tb_uart_rx;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_error;
    logic       busy;

    uart_rx #(.CLK_DIV(DIV)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observed events
    int         ev_cyc[$];
    logic [7:0] ev_data[$];
    bit         ev_err[$];
    bit         ev_busy[$];
    bit         ev_pbusy[$];
    logic       prev_pulse = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rx_done || frame_error) begin
            check("one_hot", 32'(rx_done & frame_error), 0);
            check("no_repeat", 32'(prev_pulse), 0);
            ev_cyc.push_back(cyc);
            ev_data.push_back(rx_data);
            ev_err.push_back(frame_error);
            ev_busy.push_back(busy);
            ev_pbusy.push_back(prev_busy);
        end
        prev_pulse = rx_done | frame_error;
        prev_busy  = busy;
    end

    // reference model: one entry per frame outcome
    bit         exp_err[$];
    logic [7:0] exp_data[$];
    logic [7:0] last_good = 8'h00;

    task automatic push_exp(input bit ok, input logic [7:0] b);
        if (ok) begin
            last_good = b;
            exp_err.push_back(1'b0);
            exp_data.push_back(b);
        end else begin
            exp_err.push_back(1'b1);
            exp_data.push_back(last_good);
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, ev_err.size(), exp_err.size());
        while (ev_err.size() > 0 && exp_err.size() > 0) begin
            check({tag, "_kind"}, 32'(ev_err.pop_front()),
                  32'(exp_err.pop_front()));
            check({tag, "_data"}, 32'(ev_data.pop_front()),
                  32'(exp_data.pop_front()));
        end
        ev_cyc.delete();
        ev_data.delete();
        ev_err.delete();
        ev_busy.delete();
        ev_pbusy.delete();
        exp_err.delete();
        exp_data.delete();
    endtask

    // pm = bit period in thousandths of a cycle; glitch < 0 means none
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int pm, input int glitch,
                              input int max_slots, output int k);
        int   total;
        int   bi;
        logic v;
        total = (10 * pm) / 1000;
        k = cyc + 1;
        for (int s = 0; s < total && s < max_slots; s++) begin
            bi = (s * 1000) / pm;
            if (bi == 0) v = 1'b0;
            else if (bi <= 8) v = b[bi-1];
            else v = stop_ok;
            if (glitch >= 0 && s == ((glitch + 1) * pm + pm / 2) / 1000)
                v = ~v;
            rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * DIV) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"}, 32'(rx_data), 0);
        check({tag, "_done"}, 32'(rx_done), 0);
        check({tag, "_ferr"}, 32'(frame_error), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int         k;
        int         k0;
        int         pm;
        int         g;
        int         gap;
        bit         ok;
        logic [7:0] b;
        logic [7:0] stream[6] = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        idle(2);

        // good byte with exact latency
        send_frame(8'hD5, 1'b1, 8000, -1, 1000, k);
        idle(2);
        check("good_n", ev_cyc.size(), 1);
        if (ev_cyc.size() > 0) begin
            check("good_cyc", ev_cyc[0], k + 2 + DIV / 2 + 9 * DIV);
            check("good_busy_after", 32'(ev_busy[0]), 0);
            check("good_busy_before", 32'(ev_pbusy[0]), 1);
        end
        push_exp(1'b1, 8'hD5);
        drain("good");

        // two-cycle low pulse is a false start
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(6);
        check("false_busy", 32'(busy), 0);
        drain("false");

        // single-cycle inversion at centre of data bit 3
        send_frame(8'hD5, 1'b1, 8000, 3, 1000, k);
        push_exp(1'b1, 8'hD5);
        idle(2);
        drain("glitch");

        // bad stop, long break, then a clean byte
        send_frame(8'h03, 1'b0, 8000, -1, 1000, k);
        push_exp(1'b0, 8'h03);
        rx = 1'b0;
        repeat (30 * DIV) @(posedge clk);
        #1;
        idle(2);
        send_frame(8'h01, 1'b1, 8000, -1, 1000, k);
        push_exp(1'b1, 8'h01);
        idle(2);
        drain("break");

        // back-to-back stream
        k0 = 0;
        foreach (stream[i]) begin
            send_frame(stream[i], 1'b1, 8000, -1, 1000, k);
            if (i == 0) k0 = k;
            push_exp(1'b1, stream[i]);
        end
        idle(2);
        check("b2b_n", ev_cyc.size(), 6);
        for (int i = 0; i < 6 && i < ev_cyc.size(); i++)
            check("b2b_cyc", ev_cyc[i], k0 + 2 + DIV / 2 + 9 * DIV + 10 * DIV * i);
        drain("b2b");

        // reset during data bit 4
        send_frame(8'h5A, 1'b1, 8000, -1, 5 * DIV + 4, k);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midrst");
        rst = 1'b0;
        last_good = 8'h00;
        idle(2);
        send_frame(8'hCC, 1'b1, 8000, -1, 1000, k);
        push_exp(1'b1, 8'hCC);
        idle(2);
        drain("midrst");

        // random frames with baud error, glitches and bad stops
        for (int n = 0; n < 40; n++) begin
            pm  = 7840 + $urandom_range(0, 320);
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 7) != 0);
            g   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
            gap = $urandom_range(0, 2);
            if (!ok && gap == 0) gap = 1;
            send_frame(b, ok, pm, g, 1000, k);
            push_exp(ok, b);
            if (gap > 0) idle(gap);
        end
        idle(3);
        drain("rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
